round_controller: RTL and testbench
===================================

// Module: round_controller
// PURPOSE
//  Game-round sequencer for the switch game. Requests a prompt from the LED prompt
//  generator, runs the per-round countdown and consumes switch-check results.
//  Scores passed rounds (+2, doubling every 5 passed rounds), runs the 5 s gap
//  between rounds and declares game over on a wrong flip or a timeout.
//  Sits between the KEY/switch-event logic and the HEX/LED display logic.
// PARAMETERS
//  TICK_DIV     50_000_000  clk cycles per 1 s tick
//  ROUND_SECS   15          countdown loaded at round start
//  GAP_SECS     5           countdown loaded between rounds
//  BASE_POINTS  2           points for a passed round before doubling
//  BONUS_EVERY  5           passed rounds per multiplier doubling
//  MAX_SHIFT    4           multiplier cap (BASE_POINTS << MAX_SHIFT)
//  SCORE_W      14          score width
// PORTS
//  clk          in   1        system clock (CLOCK_50)
//  reset_btn    in   1        async reset, active-high
//  start        in   1        1-cycle pulse, (re)start game
//  prompt_req   out  1        level; high until prompt_ack sampled high
//  prompt_ack   in   1        prompt generator has latched a new expected arrangement
//  sw_event     in   1        1-cycle pulse, switch check result valid
//  sw_correct   in   1        check result; qualified by sw_event
//  secs_left    out  6        current countdown value (to HEX4/HEX5 decode)
//  score        out  SCORE_W  accumulated score, saturating
//  round_num    out  8        rounds passed, saturating at 255
//  playing      out  1        high in PLAY (gates LED prompts)
//  game_over    out  1        high in OVER
//  high_score   out  SCORE_W  best score; see CONFIGURATION
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; tick counter, streak, shift 0.
//  - States: IDLE, REQ, PLAY, GAP, OVER.
//  - IDLE -start-> REQ. On entry to REQ from IDLE/OVER/restart: score, round_num,
//    streak and shift are cleared.
//  - REQ: prompt_req=1; on the cycle prompt_ack=1 -> PLAY, secs_left<=ROUND_SECS,
//    tick counter cleared. prompt_req is low from the next cycle on.
//  - PLAY: sw_event&sw_correct -> GAP, secs_left<=GAP_SECS,
//    score<=sat(score+(BASE_POINTS<<shift)), round_num<=sat(round_num+1), streak++.
//    When streak reaches BONUS_EVERY: streak<=0, shift<=min(shift+1,MAX_SHIFT).
//    The multiplier applies from the next round on.
//  - PLAY: sw_event&!sw_correct -> OVER. Tick with secs_left==1 -> secs_left<=0, OVER.
//  - GAP: tick with secs_left==1 -> secs_left<=0, REQ (score kept).
//  - OVER: hold all values; start -> REQ.
//  - sw_event outside PLAY is ignored. prompt_ack outside REQ is ignored.
//  - Tick: 1-cycle strobe every TICK_DIV cycles; secs_left decrements on tick in
//    PLAY/GAP only; the tick counter is cleared on every PLAY/GAP entry, so every
//    countdown second is exactly TICK_DIV cycles.
//  - Priority in the same cycle: reset_btn > start > sw_event > tick timeout.
//    start in any state -> REQ with clear.
//  - Latency: all outputs registered, update 1 cycle after the triggering input.
//  - Saturation: score clamps at 2^SCORE_W-1; round_num clamps at 255.
// CONFIGURATION
//  HIGH_SCORE_EN defined: high_score register, reset 0. On entry to OVER, if
//    score>high_score then high_score<=score. It survives start and is cleared
//    only by reset_btn.
//  HIGH_SCORE_EN undefined: no register; high_score tied to 0.
// STRUCTURE
//  switch_game_pkg: state enum (IDLE,REQ,PLAY,GAP,OVER), SCORE_W, round width 8.
//  Sub-module sec_tick_gen (TICK_DIV, clk, reset_btn, clear -> tick): the only
//  divider in the block.
// TESTING (TICK_DIV=4 for all scenarios)
//  - reset, start, ack 3 cycles later -> prompt_req high 3 cycles; PLAY,
//    secs_left=15.
//  - PLAY, no event -> secs_left 15..1..0 every 4 cycles; OVER, game_over=1, score=0.
//  - 6 correct rounds -> scores 2,4,6,8,10 then 14; round_num=6; GAP 5 s; REQ
//    after each round.
//  - wrong flip in round 3 -> OVER, score=4; a later sw_event leaves the score
//    unchanged; start -> score=0.
//  - sw_event&sw_correct on the same cycle as final tick -> GAP, score+=2, not OVER.
//  - HIGH_SCORE_EN: game1 score=4, game2 score=2 -> high_score=4. reset_btn
//    mid-PLAY -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/switch_game_pkg.sv
// Shared types and widths for the switch game round logic.
package switch_game_pkg;

    localparam int unsigned SCORE_W = 14;
    localparam int unsigned ROUND_W = 8;
    localparam int unsigned SECS_W  = 6;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        PLAY = 3'd2,
        GAP  = 3'd3,
        OVER = 3'd4
    } state_t;

endpackage

// File: rtl/sec_tick_gen.sv
// One-second strobe divider; clear restarts the second so the next tick is a full
// TICK_DIV cycles away. Tick is registered (asserted one cycle before the count wraps).
module sec_tick_gen #(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset_btn,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset_btn) begin
        if (reset_btn) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (clear) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= (cnt == CNT_W'(TICK_DIV - 2));
            cnt  <= (cnt == CNT_W'(TICK_DIV - 1)) ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/round_controller.sv
// Game-round sequencer: prompt request, round countdown, scoring, inter-round gap.
// Optional best-score register enabled with `define HIGH_SCORE_EN.
module round_controller
    import switch_game_pkg::*;
#(
    parameter int unsigned TICK_DIV    = 50_000_000,
    parameter int unsigned ROUND_SECS  = 15,
    parameter int unsigned GAP_SECS    = 5,
    parameter int unsigned BASE_POINTS = 2,
    parameter int unsigned BONUS_EVERY = 5,
    parameter int unsigned MAX_SHIFT   = 4
) (
    input  logic               clk,
    input  logic               reset_btn,
    input  logic               start,
    output logic               prompt_req,
    input  logic               prompt_ack,
    input  logic               sw_event,
    input  logic               sw_correct,
    output logic [SECS_W-1:0]  secs_left,
    output logic [SCORE_W-1:0] score,
    output logic [ROUND_W-1:0] round_num,
    output logic               playing,
    output logic               game_over,
    output logic [SCORE_W-1:0] high_score
);

    localparam int unsigned SHIFT_W  = $clog2(MAX_SHIFT + 1);
    localparam int unsigned STREAK_W = $clog2(BONUS_EVERY + 1);

    state_t              state, state_next;
    logic                tick;
    logic                tick_clear_c;
    logic                clear_game_c;
    logic                pass_c;
    logic                load_round_c;
    logic                dec_c;
    logic [STREAK_W-1:0] streak;
    logic [SHIFT_W-1:0]  shift;
    logic [SCORE_W-1:0]  points_c;
    logic [SCORE_W:0]    sum_c;
    logic [SCORE_W-1:0]  score_inc_c;

    sec_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk       (clk),
        .reset_btn (reset_btn),
        .clear     (tick_clear_c),
        .tick      (tick)
    );

    always_ff @(posedge clk or posedge reset_btn) begin
        if (reset_btn) state <= IDLE;
        else            state <= state_next;
    end

    // Next state; start overrides everything else in the same cycle.
    always_comb begin
        state_next   = state;
        clear_game_c = 1'b0;
        pass_c       = 1'b0;
        load_round_c = 1'b0;
        dec_c        = 1'b0;
        case (state)
            IDLE: ;
            REQ: begin
                if (prompt_ack) begin
                    state_next   = PLAY;
                    load_round_c = 1'b1;
                end
            end
            PLAY: begin
                if (sw_event) begin
                    state_next = sw_correct ? GAP : OVER;
                    pass_c     = sw_correct;
                end else if (tick) begin
                    dec_c = 1'b1;
                    if (secs_left == SECS_W'(1)) state_next = OVER;
                end
            end
            GAP: begin
                if (tick) begin
                    dec_c = 1'b1;
                    if (secs_left == SECS_W'(1)) state_next = REQ;
                end
            end
            OVER: ;
            default: state_next = IDLE;
        endcase
        if (start) begin
            state_next   = REQ;
            clear_game_c = 1'b1;
            pass_c       = 1'b0;
            load_round_c = 1'b0;
            dec_c        = 1'b0;
        end
        // Divider held in clear outside the countdown states and on PLAY->GAP,
        // so each countdown starts on a fresh second.
        tick_clear_c = !(state == PLAY || state == GAP) ||
                       (state == PLAY && state_next != PLAY);
    end

    always_comb begin
        points_c    = SCORE_W'(BASE_POINTS) << shift;
        sum_c       = {1'b0, score} + {1'b0, points_c};
        score_inc_c = sum_c[SCORE_W] ? '1 : sum_c[SCORE_W-1:0];
    end

    always_ff @(posedge clk or posedge reset_btn) begin
        if (reset_btn) begin
            prompt_req <= 1'b0;
            playing    <= 1'b0;
            game_over  <= 1'b0;
            secs_left  <= '0;
            score      <= '0;
            round_num  <= '0;
            streak     <= '0;
            shift      <= '0;
        end else begin
            prompt_req <= (state_next == REQ);
            playing    <= (state_next == PLAY);
            game_over  <= (state_next == OVER);

            if (load_round_c)  secs_left <= SECS_W'(ROUND_SECS);
            else if (pass_c)   secs_left <= SECS_W'(GAP_SECS);
            else if (dec_c)    secs_left <= secs_left - SECS_W'(1);

            if (clear_game_c) begin
                score     <= '0;
                round_num <= '0;
                streak    <= '0;
                shift     <= '0;
            end else if (pass_c) begin
                score     <= score_inc_c;
                round_num <= (round_num == '1) ? round_num : round_num + ROUND_W'(1);
                // Multiplier doubling takes effect from the following round.
                if (streak == STREAK_W'(BONUS_EVERY - 1)) begin
                    streak <= '0;
                    shift  <= (shift >= SHIFT_W'(MAX_SHIFT)) ? SHIFT_W'(MAX_SHIFT)
                                                             : shift + SHIFT_W'(1);
                end else begin
                    streak <= streak + STREAK_W'(1);
                end
            end
        end
    end

`ifdef HIGH_SCORE_EN
    always_ff @(posedge clk or posedge reset_btn) begin
        if (reset_btn) begin
            high_score <= '0;
        end else if (state_next == OVER && state != OVER && score > high_score) begin
            high_score <= score;
        end
    end
`else
    assign high_score = '0;
`endif

endmodule

// File: tb/tb_round_controller.sv
// Directed bench for round_controller with TICK_DIV=4: vector table plus
// hand-written multi-cycle sequences (timeout, scoring, gap, priority, reset).
module tb_round_controller;
    import switch_game_pkg::*;

`ifdef HIGH_SCORE_EN
    localparam logic [SCORE_W-1:0] HS_AFTER_GAMES = 14'd4;
`else
    localparam logic [SCORE_W-1:0] HS_AFTER_GAMES = 14'd0;
`endif

    logic               clk = 1'b0;
    logic               reset_btn = 1'b0;
    logic               start = 1'b0;
    logic               prompt_ack = 1'b0;
    logic               sw_event = 1'b0;
    logic               sw_correct = 1'b0;
    logic               prompt_req;
    logic [SECS_W-1:0]  secs_left;
    logic [SCORE_W-1:0] score;
    logic [ROUND_W-1:0] round_num;
    logic               playing;
    logic               game_over;
    logic [SCORE_W-1:0] high_score;

    int checks = 0;
    int errors = 0;

    round_controller #(.TICK_DIV(4)) dut (
        .clk        (clk),
        .reset_btn  (reset_btn),
        .start      (start),
        .prompt_req (prompt_req),
        .prompt_ack (prompt_ack),
        .sw_event   (sw_event),
        .sw_correct (sw_correct),
        .secs_left  (secs_left),
        .score      (score),
        .round_num  (round_num),
        .playing    (playing),
        .game_over  (game_over),
        .high_score (high_score)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic               s, a, e, c;
        logic               req, play, over;
        logic [SECS_W-1:0]  secs;
        logic [SCORE_W-1:0] sc;
        logic [ROUND_W-1:0] rn;
    } vec_t;

    vec_t vecs[14];

    task automatic step(input logic s, input logic a, input logic e, input logic c);
        start = s; prompt_ack = a; sw_event = e; sw_correct = c;
        @(posedge clk); #1;
        start = 1'b0; prompt_ack = 1'b0; sw_event = 1'b0; sw_correct = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check(input string name, input logic req, input logic play,
                         input logic over, input logic [SECS_W-1:0] secs,
                         input logic [SCORE_W-1:0] sc, input logic [ROUND_W-1:0] rn);
        checks++;
        if ({prompt_req, playing, game_over, secs_left, score, round_num} !==
            {req, play, over, secs, sc, rn}) begin
            errors++;
            $display("FAIL %s: got req=%b play=%b over=%b secs=%0d score=%0d round=%0d, want req=%b play=%b over=%b secs=%0d score=%0d round=%0d",
                     name, prompt_req, playing, game_over, secs_left, score, round_num,
                     req, play, over, secs, sc, rn);
        end
    endtask

    task automatic check_hs(input string name, input logic [SCORE_W-1:0] exp);
        checks++;
        if (high_score !== exp) begin
            errors++;
            $display("FAIL %s: got high_score=%0d, want %0d", name, high_score, exp);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [SCORE_W-1:0] exp_sc[6];
        exp_sc[0] = 14'd2;  exp_sc[1] = 14'd4; exp_sc[2] = 14'd6;
        exp_sc[3] = 14'd8;  exp_sc[4] = 14'd10; exp_sc[5] = 14'd14;

        //              s     a     e     c     req   play  over  secs   score   round
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0,  14'd0, 8'd0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0,  14'd0, 8'd0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0,  14'd0, 8'd0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd15, 14'd0, 8'd0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd15, 14'd0, 8'd0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd5,  14'd2, 8'd1};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd5,  14'd2, 8'd1};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd5,  14'd2, 8'd1};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd5,  14'd0, 8'd0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd15, 14'd0, 8'd0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'd15, 14'd0, 8'd0};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 6'd15, 14'd0, 8'd0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd15, 14'd0, 8'd0};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd15, 14'd0, 8'd0};

        reset_btn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset", 1'b0, 1'b0, 1'b0, 6'd0, 14'd0, 8'd0);
        check_hs("reset_hs", 14'd0);
        reset_btn = 1'b0;

        for (int i = 0; i < 14; i++) begin
            step(vecs[i].s, vecs[i].a, vecs[i].e, vecs[i].c);
            check($sformatf("vec%0d", i), vecs[i].req, vecs[i].play, vecs[i].over,
                  vecs[i].secs, vecs[i].sc, vecs[i].rn);
        end

        // Full countdown with no event: one second per 4 cycles, then OVER.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("timeout_entry", 1'b0, 1'b1, 1'b0, 6'd15, 14'd0, 8'd0);
        for (int i = 1; i <= 60; i++) begin
            idle(1);
            if (i < 60)
                check($sformatf("timeout_c%0d", i), 1'b0, 1'b1, 1'b0,
                      SECS_W'(15 - i / 4), 14'd0, 8'd0);
            else
                check("timeout_over", 1'b0, 1'b0, 1'b1, 6'd0, 14'd0, 8'd0);
        end

        // Six passed rounds: doubling kicks in on the sixth.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int r = 0; r < 6; r++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1);
            check($sformatf("pass%0d", r + 1), 1'b0, 1'b0, 1'b0, 6'd5, exp_sc[r], ROUND_W'(r + 1));
            idle(19);
            check($sformatf("gap_last%0d", r + 1), 1'b0, 1'b0, 1'b0, 6'd1, exp_sc[r], ROUND_W'(r + 1));
            idle(1);
            check($sformatf("gap_req%0d", r + 1), 1'b1, 1'b0, 1'b0, 6'd0, exp_sc[r], ROUND_W'(r + 1));
            step(1'b0, 1'b1, 1'b0, 1'b0);
            check($sformatf("replay%0d", r + 1), 1'b0, 1'b1, 1'b0, 6'd15, exp_sc[r], ROUND_W'(r + 1));
        end

        // Game 1: wrong flip in round 3.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("g1_restart", 1'b1, 1'b0, 1'b0, 6'd15, 14'd0, 8'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int r = 0; r < 2; r++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1);
            idle(20);
            step(1'b0, 1'b1, 1'b0, 1'b0);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("g1_wrong", 1'b0, 1'b0, 1'b1, 6'd15, 14'd4, 8'd2);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        check("g1_late_event", 1'b0, 1'b0, 1'b1, 6'd15, 14'd4, 8'd2);
        check_hs("g1_hs", HS_AFTER_GAMES);

        // Game 2: lower score must not replace the best score.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("g2_start", 1'b1, 1'b0, 1'b0, 6'd15, 14'd0, 8'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        idle(20);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("g2_wrong", 1'b0, 1'b0, 1'b1, 6'd15, 14'd2, 8'd1);
        check_hs("g2_hs", HS_AFTER_GAMES);

        // Correct flip on the same cycle as the final tick wins over timeout.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(59);
        check("race_pre", 1'b0, 1'b1, 1'b0, 6'd1, 14'd0, 8'd0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        check("race_gap", 1'b0, 1'b0, 1'b0, 6'd5, 14'd2, 8'd1);
        idle(3);
        check("race_gap_hold", 1'b0, 1'b0, 1'b0, 6'd5, 14'd2, 8'd1);
        idle(1);
        check("race_gap_tick", 1'b0, 1'b0, 1'b0, 6'd4, 14'd2, 8'd1);

        // start beats a simultaneous correct flip.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        check("start_prio", 1'b1, 1'b0, 1'b0, 6'd15, 14'd0, 8'd0);

        // Asynchronous reset in the middle of PLAY.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        idle(20);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("pre_reset", 1'b0, 1'b1, 1'b0, 6'd15, 14'd2, 8'd1);
        #2;
        reset_btn = 1'b1;
        #1;
        check("async_reset", 1'b0, 1'b0, 1'b0, 6'd0, 14'd0, 8'd0);
        check_hs("async_reset_hs", 14'd0);
        @(posedge clk); #1;
        reset_btn = 1'b0;
        idle(2);
        check("post_reset_idle", 1'b0, 1'b0, 1'b0, 6'd0, 14'd0, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
